nn_dpmem_resp: RTL and testbench

//  Dual-port synchronous memory responder. It answers the active-low WEB/OEB/CSB + ADD

---
 rtl/nn_dpmem_resp_pkg.sv | 30 +++
 rtl/nn_dpmem_resp_port.sv | 56 +++++
 rtl/nn_dpmem_resp.sv | 141 ++++++++++++++
 tb/tb_nn_dpmem_resp.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_dpmem_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_mem_pkg
//  Description : Shared types, default sizes and the per-port op decoder for
//                the neural-net dual-port memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
package nn_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 32;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_t;

  // Active-low chip select gates everything; write enable picks the direction.
  function automatic mem_op_t dec_op(input logic csb, input logic web);
    mem_op_t op;
    if (csb)      op = OP_IDLE;
    else if (web) op = OP_READ;
    else          op = OP_WRITE;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_dpmem_resp_port.sv
`default_nettype none
// ============================================================================
//  Module      : nn_mem_port
//  Description : One memory port: op decode, address range check, registered
//                read data with a one-cycle valid pulse, and the output-enable
//                gate on the read data.
//  Revision    : 1.0  initial release
// ============================================================================
module nn_mem_port
  import nn_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csb,
  input  logic              web,
  input  logic              oeb,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] rdata,
  output mem_op_t           op,
  output logic              in_range,
  output logic [DATA_W-1:0] dout,
  output logic              dval
);

  mem_op_t           w_op;
  logic              w_in_range;
  logic [DATA_W-1:0] r_dout;
  logic              r_dval;

  assign w_op       = dec_op(csb, web);
  assign w_in_range = (32'(add) < DEPTH);

  // Read loads the word (or zero when out of range) and pulses valid; other ops hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
      r_dval <= 1'b0;
    end else begin
      r_dval <= (w_op == OP_READ);
      if (w_op == OP_READ) begin
        r_dout <= w_in_range ? rdata : '0;
      end
    end
  end

  assign op       = w_op;
  assign in_range = w_in_range;
  assign dout     = oeb ? '0 : r_dout;
  assign dval     = r_dval;

endmodule
`default_nettype wire

// File: rtl/nn_dpmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : nn_dpmem_resp
//  Description : Dual-port synchronous memory responder for the kernel and
//                weight memories. Read-first on cross-port conflicts, port 1
//                wins write/write conflicts, sticky collision and address
//                error flags, saturating write counter.
//  Revision    : 1.0  initial release
// ============================================================================
module nn_dpmem_resp
  import nn_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ADD1,
  input  logic              WEB1,
  input  logic              OEB1,
  input  logic              CSB1,
  input  logic [DATA_W-1:0] DIN1,
  output logic [DATA_W-1:0] DOUT1,
  output logic              DVAL1,
  input  logic [ADDR_W-1:0] ADD2,
  input  logic              WEB2,
  input  logic              OEB2,
  input  logic              CSB2,
  input  logic [DATA_W-1:0] DIN2,
  output logic [DATA_W-1:0] DOUT2,
  output logic              DVAL2,
  output logic              COLL,
  output logic              AERR,
  input  logic              CLR,
  output logic [7:0]        WCNT
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  mem_op_t           w_op1, w_op2;
  logic              w_rng1, w_rng2;
  logic [ADDR_W-1:0] w_idx1, w_idx2;
  logic [DATA_W-1:0] w_rdata1, w_rdata2;
  logic              w_wr1, w_wr2;
  logic              w_coll_ev, w_aerr_ev;
  logic [1:0]        w_inc;
  logic [8:0]        w_sum;
  logic [7:0]        w_wcnt_nxt;
  logic              r_coll, r_aerr;
  logic [7:0]        r_wcnt;

  // Out-of-range addresses are steered to word 0 so the array is never over-indexed;
  // the port discards that data anyway.
  assign w_idx1   = w_rng1 ? ADD1 : '0;
  assign w_idx2   = w_rng2 ? ADD2 : '0;
  assign w_rdata1 = r_mem[w_idx1];
  assign w_rdata2 = r_mem[w_idx2];

  nn_mem_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_port1 (
    .clk      (clk),
    .rst      (rst),
    .csb      (CSB1),
    .web      (WEB1),
    .oeb      (OEB1),
    .add      (ADD1),
    .rdata    (w_rdata1),
    .op       (w_op1),
    .in_range (w_rng1),
    .dout     (DOUT1),
    .dval     (DVAL1)
  );

  nn_mem_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_port2 (
    .clk      (clk),
    .rst      (rst),
    .csb      (CSB2),
    .web      (WEB2),
    .oeb      (OEB2),
    .add      (ADD2),
    .rdata    (w_rdata2),
    .op       (w_op2),
    .in_range (w_rng2),
    .dout     (DOUT2),
    .dval     (DVAL2)
  );

  // Only in-range writes are accepted; they both update memory and count.
  assign w_wr1     = (w_op1 == OP_WRITE) && w_rng1;
  assign w_wr2     = (w_op2 == OP_WRITE) && w_rng2;
  assign w_coll_ev = w_wr1 && w_wr2 && (ADD1 == ADD2);
  assign w_aerr_ev = ((w_op1 != OP_IDLE) && !w_rng1) ||
                     ((w_op2 != OP_IDLE) && !w_rng2);

  assign w_inc      = {1'b0, w_wr1} + {1'b0, w_wr2};
  assign w_sum      = {1'b0, r_wcnt} + {7'd0, w_inc};
  assign w_wcnt_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];

  // Storage array; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr2) r_mem[ADD2] <= DIN2;
      if (w_wr1) r_mem[ADD1] <= DIN1;
    end
  end

  // Sticky flags: clear drops them, but an event in the same cycle keeps them set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll <= 1'b0;
      r_aerr <= 1'b0;
    end else begin
      r_coll <= (r_coll && !CLR) || w_coll_ev;
      r_aerr <= (r_aerr && !CLR) || w_aerr_ev;
    end
  end

  // Saturating count of accepted port writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wcnt <= 8'd0;
    else     r_wcnt <= w_wcnt_nxt;
  end

  assign COLL = r_coll;
  assign AERR = r_aerr;
  assign WCNT = r_wcnt;

endmodule
`default_nettype wire

// File: tb/tb_nn_dpmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nn_dpmem_resp
//  Description : Self-checking bench for nn_dpmem_resp: a 32-word instance
//                with queued read expectations, plus a 20-word instance for
//                address-range and counter saturation behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nn_dpmem_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-word instance
  logic [4:0] m_add1, m_add2;
  logic       m_web1, m_oeb1, m_csb1, m_web2, m_oeb2, m_csb2, m_clr;
  logic [7:0] m_din1, m_din2, m_dout1, m_dout2, m_wcnt;
  logic       m_dval1, m_dval2, m_coll, m_aerr;

  // 20-word instance
  logic [4:0] b_add1, b_add2;
  logic       b_web1, b_oeb1, b_csb1, b_web2, b_oeb2, b_csb2, b_clr;
  logic [7:0] b_din1, b_din2, b_dout1, b_dout2, b_wcnt;
  logic       b_dval1, b_dval2, b_coll, b_aerr;

  int checks = 0;
  int errors = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  nn_dpmem_resp #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .ADD1(m_add1), .WEB1(m_web1), .OEB1(m_oeb1), .CSB1(m_csb1), .DIN1(m_din1),
    .DOUT1(m_dout1), .DVAL1(m_dval1),
    .ADD2(m_add2), .WEB2(m_web2), .OEB2(m_oeb2), .CSB2(m_csb2), .DIN2(m_din2),
    .DOUT2(m_dout2), .DVAL2(m_dval2),
    .COLL(m_coll), .AERR(m_aerr), .CLR(m_clr), .WCNT(m_wcnt)
  );

  nn_dpmem_resp #(.ADDR_W(5), .DATA_W(8), .DEPTH(20)) dut20 (
    .clk(clk), .rst(rst),
    .ADD1(b_add1), .WEB1(b_web1), .OEB1(b_oeb1), .CSB1(b_csb1), .DIN1(b_din1),
    .DOUT1(b_dout1), .DVAL1(b_dval1),
    .ADD2(b_add2), .WEB2(b_web2), .OEB2(b_oeb2), .CSB2(b_csb2), .DIN2(b_din2),
    .DOUT2(b_dout2), .DVAL2(b_dval2),
    .COLL(b_coll), .AERR(b_aerr), .CLR(b_clr), .WCNT(b_wcnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse on the 32-word instance is matched to a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_dval1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL port1_unexpected_dval actual=%0h required=none", m_dout1);
        end else begin
          logic [7:0] e1;
          e1 = q1.pop_front();
          if (m_dout1 !== e1) begin
            errors++;
            $display("FAIL port1_read actual=%0h required=%0h", m_dout1, e1);
          end
        end
      end
      if (m_dval2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL port2_unexpected_dval actual=%0h required=none", m_dout2);
        end else begin
          logic [7:0] e2;
          e2 = q2.pop_front();
          if (m_dout2 !== e2) begin
            errors++;
            $display("FAIL port2_read actual=%0h required=%0h", m_dout2, e2);
          end
        end
      end
    end
  end

  task automatic idle_all();
    m_csb1 = 1'b1; m_web1 = 1'b1; m_csb2 = 1'b1; m_web2 = 1'b1; m_clr = 1'b0;
    b_csb1 = 1'b1; b_web1 = 1'b1; b_csb2 = 1'b1; b_web2 = 1'b1; b_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic rd1(input logic [4:0] a, input logic [7:0] exp);
    m_csb1 = 1'b0; m_web1 = 1'b1; m_add1 = a;
    q1.push_back(exp);
    step();
  endtask

  task automatic wr_both(input logic [4:0] a1, input logic [7:0] d1,
                         input logic [4:0] a2, input logic [7:0] d2);
    m_csb1 = 1'b0; m_web1 = 1'b0; m_add1 = a1; m_din1 = d1;
    m_csb2 = 1'b0; m_web2 = 1'b0; m_add2 = a2; m_din2 = d2;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tab [0:7];
    exp_tab = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32};
    m_add1 = '0; m_add2 = '0; m_din1 = '0; m_din2 = '0; m_oeb1 = 1'b0; m_oeb2 = 1'b0;
    b_add1 = '0; b_add2 = '0; b_din1 = '0; b_din2 = '0; b_oeb1 = 1'b0; b_oeb2 = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_dval1", m_dval1, 0);
    chk("rst_dout1", m_dout1, 0);
    chk("rst_coll", m_coll, 0);
    chk("rst_aerr", m_aerr, 0);
    chk("rst_wcnt", m_wcnt, 0);

    // 1: all words read zero after reset
    for (int a = 0; a < 32; a++) rd1(5'(a), 8'h00);

    // 2: learn pattern on both ports, then read back
    for (int k = 0; k < 4; k++)
      wr_both(5'(2*k), 8'(k*16+1), 5'(2*k+1), 8'(k*16+2));
    for (int a = 0; a < 8; a++) rd1(5'(a), exp_tab[a]);
    chk("wcnt_learn", m_wcnt, 8);

    // 3: read-first on cross-port same-address access
    m_csb1 = 1'b0; m_web1 = 1'b0; m_add1 = 5'd5; m_din1 = 8'hAA;
    m_csb2 = 1'b0; m_web2 = 1'b1; m_add2 = 5'd5;
    q2.push_back(8'h22);
    step();
    m_csb2 = 1'b0; m_web2 = 1'b1; m_add2 = 5'd5;
    q2.push_back(8'hAA);
    step();
    chk("wcnt_rw", m_wcnt, 9);

    // 4: write/write collision, port 1 wins, clear behaviour
    wr_both(5'd3, 8'h55, 5'd3, 8'h66);
    chk("coll_set", m_coll, 1);
    chk("wcnt_ww", m_wcnt, 11);
    rd1(5'd3, 8'h55);
    m_clr = 1'b1;
    step();
    chk("coll_clr", m_coll, 0);
    m_clr = 1'b1;
    wr_both(5'd7, 8'h77, 5'd7, 8'h88);
    chk("coll_clr_event_wins", m_coll, 1);
    chk("wcnt_ww2", m_wcnt, 13);
    m_clr = 1'b1;
    step();
    chk("coll_clr2", m_coll, 0);

    // 5: output gate
    m_oeb1 = 1'b1;
    rd1(5'd3, 8'h00);
    step();
    m_oeb1 = 1'b0;
    #1;
    chk("oeb_release_dout", m_dout1, 8'h55);
    chk("oeb_release_dval", m_dval1, 0);

    // 6: address range and counter saturation on the 20-word instance
    b_csb1 = 1'b0; b_web1 = 1'b0; b_add1 = 5'd4; b_din1 = 8'h77;
    step();
    b_csb1 = 1'b0; b_web1 = 1'b1; b_add1 = 5'd4;
    step();
    chk("d20_read4", b_dout1, 8'h77);
    chk("d20_aerr_clean", b_aerr, 0);
    b_csb1 = 1'b0; b_web1 = 1'b0; b_add1 = 5'd25; b_din1 = 8'h99;
    step();
    chk("d20_wcnt_drop", b_wcnt, 1);
    chk("d20_aerr", b_aerr, 1);
    b_csb1 = 1'b0; b_web1 = 1'b1; b_add1 = 5'd25;
    step();
    chk("d20_oor_dval", b_dval1, 1);
    chk("d20_oor_dout", b_dout1, 0);
    for (int i = 0; i < 126; i++) begin
      b_csb1 = 1'b0; b_web1 = 1'b0; b_add1 = 5'd0; b_din1 = 8'(i);
      b_csb2 = 1'b0; b_web2 = 1'b0; b_add2 = 5'd1; b_din2 = 8'(i);
      step();
    end
    chk("d20_wcnt_253", b_wcnt, 253);
    b_csb1 = 1'b0; b_web1 = 1'b0; b_add1 = 5'd0;
    step();
    chk("d20_wcnt_254", b_wcnt, 254);
    b_csb1 = 1'b0; b_web1 = 1'b0; b_add1 = 5'd0;
    b_csb2 = 1'b0; b_web2 = 1'b0; b_add2 = 5'd1;
    step();
    chk("d20_wcnt_sat", b_wcnt, 255);
    b_csb1 = 1'b0; b_web1 = 1'b0; b_add1 = 5'd0;
    b_csb2 = 1'b0; b_web2 = 1'b0; b_add2 = 5'd1;
    step();
    chk("d20_wcnt_hold", b_wcnt, 255);

    // rst mid-read: set a flag, start a read, then reset inside the valid cycle
    wr_both(5'd9, 8'h01, 5'd9, 8'h02);
    chk("coll_before_rst", m_coll, 1);
    m_csb1 = 1'b0; m_web1 = 1'b1; m_add1 = 5'd3;
    step();
    chk("dval_before_rst", m_dval1, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_dval1", m_dval1, 0);
    chk("rst_mid_dout1", m_dout1, 0);
    chk("rst_mid_coll", m_coll, 0);
    chk("rst_mid_wcnt", m_wcnt, 0);
    chk("rst_mid_d20_aerr", b_aerr, 0);
    chk("rst_mid_d20_wcnt", b_wcnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
